operand_fwd_stage: RTL

OPERAND_FWD_STAGE -- requirements
Module: operand_fwd_stage

---
 rtl/operand_fwd_stage_pkg.sv | 27 ++
 rtl/operand_fwd_stage_fwd_resolve.sv | 40 ++++
 rtl/operand_fwd_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/operand_fwd_stage_pkg.sv
// Shared types and constants for the operand forwarding stage: operand select
// codes, skid-buffer states and the PC increment constant.
package operand_fwd_stage_pkg;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2,
        OPA_RSVD = 2'd3
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_RS2  = 2'd0,
        OPB_IMM  = 2'd1,
        OPB_FOUR = 2'd2,
        OPB_RSVD = 2'd3
    } opb_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/operand_fwd_stage_fwd_resolve.sv
// Combinational priority match of one source register against the forwarding
// sources; forwarding is compiled in only when OPERAND_FWD_STAGE_FWD_EN is defined.
module fwd_resolve #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic [4:0]           rs_addr,
    input  logic [XLEN-1:0]      rs_data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [5*NFWD-1:0]    fwd_addr,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic [XLEN-1:0]      resolved
);

`ifdef OPERAND_FWD_STAGE_FWD_EN
    logic [NFWD-1:0] match;

    // x0 is hard-wired zero in the register file, so it is never forwarded.
    for (genvar gi = 0; gi < NFWD; gi++) begin : g_match
        assign match[gi] = fwd_valid[gi] && (fwd_addr[gi*5 +: 5] == rs_addr)
                           && (rs_addr != 5'd0);
    end

    // Walk from the lowest priority upward so the lowest index wins.
    always_comb begin
        resolved = rs_data;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (match[k]) begin
                resolved = fwd_data[k*XLEN +: XLEN];
            end
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{rs_addr, fwd_valid, fwd_addr, fwd_data};
    assign resolved   = rs_data;
`endif

endmodule

// File: rtl/operand_fwd_stage.sv
// Operand selection with register forwarding, buffered by a 2-entry skid buffer.
// Forwarding is enabled by defining OPERAND_FWD_STAGE_FWD_EN.
module operand_fwd_stage
    import operand_fwd_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [1:0]           i_opa_sel,
    input  logic [1:0]           i_opb_sel,
    input  logic [XLEN-1:0]      i_pc,
    input  logic [XLEN-1:0]      i_rs1_data,
    input  logic [XLEN-1:0]      i_rs2_data,
    input  logic [XLEN-1:0]      i_imm,
    input  logic [4:0]           i_rs1_addr,
    input  logic [4:0]           i_rs2_addr,
    input  logic [NFWD-1:0]      i_fwd_valid,
    input  logic [5*NFWD-1:0]    i_fwd_addr,
    input  logic [XLEN*NFWD-1:0] i_fwd_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [XLEN-1:0]      o_operand_a,
    output logic [XLEN-1:0]      o_operand_b
);

    logic [XLEN-1:0] rs1_res;
    logic [XLEN-1:0] rs2_res;
    logic [XLEN-1:0] opa_new;
    logic [XLEN-1:0] opb_new;

    skid_state_e     state_reg;
    skid_state_e     state_next;
    logic [XLEN-1:0] head_a_reg;
    logic [XLEN-1:0] head_b_reg;
    logic [XLEN-1:0] tail_a_reg;
    logic [XLEN-1:0] tail_b_reg;

    logic accept;
    logic drain;
    logic load_head_new;
    logic load_tail_new;
    logic shift_tail;

    fwd_resolve #(.XLEN(XLEN), .NFWD(NFWD)) u_rs1_resolve (
        .rs_addr   (i_rs1_addr),
        .rs_data   (i_rs1_data),
        .fwd_valid (i_fwd_valid),
        .fwd_addr  (i_fwd_addr),
        .fwd_data  (i_fwd_data),
        .resolved  (rs1_res)
    );

    fwd_resolve #(.XLEN(XLEN), .NFWD(NFWD)) u_rs2_resolve (
        .rs_addr   (i_rs2_addr),
        .rs_data   (i_rs2_data),
        .fwd_valid (i_fwd_valid),
        .fwd_addr  (i_fwd_addr),
        .fwd_data  (i_fwd_data),
        .resolved  (rs2_res)
    );

    always_comb begin
        opa_new = '0;
        case (opa_sel_e'(i_opa_sel))
            OPA_RS1: opa_new = rs1_res;
            OPA_PC:  opa_new = i_pc;
            default: opa_new = '0;
        endcase
    end

    always_comb begin
        opb_new = '0;
        case (opb_sel_e'(i_opb_sel))
            OPB_RS2:  opb_new = rs2_res;
            OPB_IMM:  opb_new = i_imm;
            OPB_FOUR: opb_new = XLEN'(PC_INCR);
            default:  opb_new = '0;
        endcase
    end

    // Ready and valid depend only on the registered state.
    assign o_in_ready  = (state_reg != ST_TWO);
    assign o_out_valid = (state_reg != ST_EMPTY);
    assign o_operand_a = head_a_reg;
    assign o_operand_b = head_b_reg;

    assign accept = i_in_valid && o_in_ready;
    assign drain  = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        load_head_new = 1'b0;
        load_tail_new = 1'b0;
        shift_tail    = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next    = ST_ONE;
                    load_head_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_head_new = 1'b1;
                end else if (accept) begin
                    state_next    = ST_TWO;
                    load_tail_new = 1'b1;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_next = ST_ONE;
                    shift_tail = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        // Flush drops everything, including a request offered this cycle.
        if (i_flush) begin
            state_next    = ST_EMPTY;
            load_head_new = 1'b0;
            load_tail_new = 1'b0;
            shift_tail    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_a_reg <= '0;
            head_b_reg <= '0;
            tail_a_reg <= '0;
            tail_b_reg <= '0;
        end else begin
            if (load_head_new) begin
                head_a_reg <= opa_new;
                head_b_reg <= opb_new;
            end else if (shift_tail) begin
                head_a_reg <= tail_a_reg;
                head_b_reg <= tail_b_reg;
            end
            if (load_tail_new) begin
                tail_a_reg <= opa_new;
                tail_b_reg <= opb_new;
            end
        end
    end

endmodule
